// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving a 1-bit ALU slice LSB first, with start/busy/done handshake.
// Optional signed-overflow reporting and signed SLT correction: define ALU_SERIAL_OVERFLOW_EN.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_ainvert,
  output logic             slice_binvert,
  output logic             slice_cin,
  output logic [1:0]       slice_op,
  output logic             slice_less,
  input  logic             slice_result,
  input  logic             slice_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef ALU_SERIAL_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d, result_q, result_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d, set_q, set_d;
  logic             cout_s_q, cout_s_d, ovf_s_q, ovf_s_d;
  logic             busy_q, busy_d, done_q, done_d, zero_q, zero_d;
  logic             carry_out_q, carry_out_d, overflow_q, overflow_d;
  logic             last_bit, ovf_bit, set_bit, is_slt, is_arith;

  // Slice drive, decoded from the current state only.
  always_comb begin
    slice_a       = 1'b0;
    slice_b       = 1'b0;
    slice_ainvert = 1'b0;
    slice_binvert = 1'b0;
    slice_cin     = 1'b0;
    slice_op      = 2'd0;
    slice_less    = 1'b0;
    case (state_q)
      RUN: begin
        slice_a       = a_q[idx_q];
        slice_b       = b_q[idx_q];
        slice_ainvert = ctl_q[3];
        slice_binvert = ctl_q[2];
        slice_cin     = carry_q;
        slice_op      = (ctl_q[1:0] == 2'd3) ? 2'd2 : ctl_q[1:0];
      end
      FIX: begin
        slice_a       = a_q[0];
        slice_b       = b_q[0];
        slice_ainvert = ctl_q[3];
        slice_binvert = ctl_q[2];
        slice_cin     = ctl_q[2];
        slice_op      = 2'd3;
        slice_less    = set_q;
      end
      default: ;
    endcase
  end

  assign last_bit = (idx_q == IDX_W'(WIDTH - 1));
  assign ovf_bit  = carry_q ^ slice_cout;
  assign set_bit  = slice_result ^ (OVF_EN & ovf_bit);
  assign is_slt   = (ctl_q[1:0] == 2'd3);
  assign is_arith = ctl_q[1];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    ctl_d       = ctl_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    work_d      = work_q;
    set_d       = set_q;
    cout_s_d    = cout_s_q;
    ovf_s_d     = ovf_s_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          ctl_d   = alu_ctl;
          carry_d = alu_ctl[2];
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[idx_q] = slice_result;
        carry_d       = slice_cout;
        idx_d         = IDX_W'(idx_q + 1'b1);
        if (last_bit) begin
          cout_s_d = slice_cout;
          ovf_s_d  = ovf_bit;
          set_d    = set_bit;
          if (is_slt) begin
            state_d = FIX;
          end else begin
            result_d    = work_d;
            zero_d      = (work_d == '0);
            carry_out_d = slice_cout;
            overflow_d  = OVF_EN & is_arith & ovf_bit;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      FIX: begin
        result_d    = WIDTH'(slice_result);
        zero_d      = ~slice_result;
        carry_out_d = cout_s_q;
        overflow_d  = OVF_EN & is_arith & ovf_s_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ctl_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      work_q      <= '0;
      set_q       <= 1'b0;
      cout_s_q    <= 1'b0;
      ovf_s_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctl_q       <= ctl_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      work_q      <= work_d;
      set_q       <= set_d;
      cout_s_q    <= cout_s_d;
      ovf_s_q     <= ovf_s_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial sequencer that sits directly upstream of the 1-bit ALU slice, with the inputs a, b, Ainvert, Binvert, CarryIn, Operation[1:0], Less and the outputs Result, CarryOut.
- Accepts a WIDTH-bit operation request and drives the slice one bit per clock, LSB first.
- Feeds the slice's CarryOut back as the next bit's CarryIn and shifts the slice's Result into a WIDTH-bit result register.
- Reports result, zero, carry-out and overflow through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (min 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request strobe; sampled only while busy=0.
- alu_ctl  input  4  {Ainvert, Binvert, Operation[1:0]}: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- op_a  input  WIDTH  operand A, captured on accept.
- op_b  input  WIDTH  operand B, captured on accept.
- slice_a  output  1  to slice a.
- slice_b  output  1  to slice b.
- slice_ainvert  output  1  to slice Ainvert.
- slice_binvert  output  1  to slice Binvert.
- slice_cin  output  1  to slice CarryIn.
- slice_op  output  2  to slice Operation.
- slice_less  output  1  to slice Less.
- slice_result  input  1  from slice Result.
- slice_cout  input  1  from slice CarryOut.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  final result, held until the next accept.
- zero  output  1  (result == 0), registered with done.
- carry_out  output  1  slice CarryOut of the MSB.
- overflow  output  1  signed overflow (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-operation): state=IDLE; busy=0, done=0, result=0, zero=0, carry_out=0, overflow=0; bit index=0; internal carry=0. The in-flight operation is discarded.
- Slice outputs are combinational from state.
  - In IDLE, all slice outputs are driven 0.
- FSM states: IDLE, RUN, FIX.
- IDLE: start=1 captures op_a, op_b and alu_ctl, sets carry = alu_ctl[2], index=0, busy=1, and moves to RUN. done is cleared the cycle after it pulses.
- RUN, bit i = index:
  - slice_a = A[i], slice_b = B[i], slice_ainvert = ctl[3], slice_binvert = ctl[2], slice_cin = carry, slice_less = 0.
  - slice_op = ctl[1:0], except ctl[1:0]=3 (SLT), where slice_op = 2 so the adder runs.
  - Each cycle: result[i] <= slice_result; carry <= slice_cout; index increments.
  - At i = WIDTH-1, latch:
    - carry_out = slice_cout.
    - ovf = carry ^ slice_cout, i.e. carry into the MSB XOR carry out of it.
    - set = MSB sum.
  - After i = WIDTH-1: go to FIX if SLT; otherwise go to IDLE with done=1, busy=0.
- FIX (SLT only, 1 cycle):
  - Slice driven with a = A[0], b = B[0], ctl as captured, slice_op = 3, slice_less = set.
  - result <= {WIDTH-1 zeros, slice_result}.
  - Then go to IDLE with done=1, busy=0.
- Latency: start accepted at edge T → busy high from T. The last RUN edge is T+WIDTH, and done, result and zero are valid in the cycle after it. SLT adds one FIX cycle.
- zero is computed from the final result and updated together with done.
- Non-listed alu_ctl codes execute generically with the same rules (deterministic, no error).
- start while busy=1: ignored; no queuing.
- start in the cycle that done is high: accepted (busy=0); done still pulses exactly one cycle.
- result, zero, carry_out and overflow hold their values until the next accept, then keep their old values until the next done.

Optional Feature:
- Macro: ALU_SERIAL_OVERFLOW_EN.
- Defined:
  - overflow = latched ovf for ADD/SUB/SLT; 0 for logic ops.
  - SLT set = MSB sum XOR ovf, which gives correct signed compare.
- Undefined:
  - overflow tied 0.
  - SLT set = MSB sum only.

Test Plan:
- Reset mid-RUN: WIDTH=8, ADD in flight, rst at bit 3 → next cycle busy=0, result=0, slice outputs 0, no done pulse.
- ADD: WIDTH=8, 0x05+0x03 → done at T+9, result=0x08, zero=0, carry_out=0; a start pulsed during busy is ignored.
- SUB and NOR:
  - 0x05−0x03 → result 0x02, carry_out=1.
  - NOR 0x0F,0xF0 → result 0x00, zero=1.
- SLT: 0x03 vs 0x05 → FIX cycle shows slice_op=3, slice_less=1; result=0x01, done at T+10. Reversed operands → 0x00.
- Overflow: ADD 0x7F+0x01 → result 0x80, overflow=1 with macro, 0 without. SLT 0x80 vs 0x01 → result 0x01 with macro, 0x00 without.
- Back-to-back: start held high through done → second op accepted the same cycle done pulses; both results correct, with one done pulse each.
